// File: rtl/clk_div_prog.sv
// -----------------------------------------------------------------------------
// clk_div_prog
//   Runtime-programmable integer clock divider. Produces a registered divided
//   clock (out_clk) and a one-cycle strobe (out_tick) on each of its rising
//   edges. A new divisor is requested through div_load/div_val and only takes
//   effect at a period boundary, so out_clk never produces a runt pulse.
//   Downstream logic is expected to use out_tick as an enable.
//
// Ports
//   clk       in   system clock, all logic on posedge
//   rst       in   synchronous reset, active-high
//   en        in   count enable; 0 freezes the divider
//   div_val   in   requested divisor, sampled when div_load=1
//   div_load  in   one-cycle load request
//   div_ack   out  one-cycle pulse: pending divisor has just become active
//   div_err   out  one-cycle pulse: load rejected (div_val < 2)
//   pending   out  an accepted divisor is waiting for a period boundary
//   div_cur   out  divisor currently in effect
//   out_clk   out  divided clock (high ceil(D/2), low floor(D/2) cycles)
//   out_tick  out  one-cycle pulse coincident with each out_clk rising edge
// -----------------------------------------------------------------------------
module clk_div_prog #(
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
  output logic             div_ack,
  output logic             div_err,
  output logic             pending,
  output logic [CNT_W-1:0] div_cur,
  output logic             out_clk,
  output logic             out_tick
);

  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);

  // Load handshake: div_load is a one-cycle request carrying div_val; there is
  // no ready, a request is always taken. A legal value (>= 2) raises pending
  // and is answered later by exactly one div_ack pulse on the boundary edge
  // that makes it active (an overwritten request is never acked). An illegal
  // value is answered by div_err on the next cycle and leaves all state alone.

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] pend_div;
  logic [CNT_W-1:0] half;
  logic             at_boundary;
  logic             load_ok;
  logic             load_bad;

  // ceil(D/2) computed without needing an extra bit: D - floor(D/2).
  assign half        = div_cur - (div_cur >> 1);
  assign at_boundary = (cnt == div_cur - ONE);
  assign load_ok     = div_load && (div_val >= TWO);
  assign load_bad    = div_load && (div_val <  TWO);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      out_clk  <= 1'b0;
      out_tick <= 1'b0;
      div_cur  <= DEF_DIV;
      pend_div <= DEF_DIV;
      pending  <= 1'b0;
      div_ack  <= 1'b0;
      div_err  <= 1'b0;
    end else begin
      div_ack  <= 1'b0;
      out_tick <= 1'b0;
      div_err  <= load_bad;

      if (en) begin
        if (at_boundary) begin
          cnt      <= '0;
          out_clk  <= 1'b1;
          out_tick <= 1'b1;
          // Swapping the divisor here is what keeps out_clk glitch-free:
          // cnt restarts at 0 in the same edge, so it is always < new D.
          if (pending) begin
            div_cur <= pend_div;
            pending <= 1'b0;
            div_ack <= 1'b1;
          end
        end else begin
          cnt <= cnt + ONE;
          if (cnt == half - ONE) begin
            out_clk <= 1'b0;
          end
        end
      end

      // Placed after the boundary logic on purpose: a load on a boundary edge
      // wins over the clear above and stays pending for the next boundary,
      // while the boundary itself used the value held before this edge.
      if (load_ok) begin
        pend_div <= div_val;
        pending  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clk_div_prog.sv
module tb_clk_div_prog;

  localparam int W  = 16;
  localparam int PW = 21;  // {ack, err, pending, div_cur, out_clk, out_tick}

  logic          clk;
  logic          rst;
  logic          en;
  logic [W-1:0]  div_val;
  logic          div_load;
  logic          div_ack;
  logic          div_err;
  logic          pending;
  logic [W-1:0]  div_cur;
  logic          out_clk;
  logic          out_tick;

  clk_div_prog #(.CNT_W(W), .DEFAULT_DIV(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .div_val  (div_val),
    .div_load (div_load),
    .div_ack  (div_ack),
    .div_err  (div_err),
    .pending  (pending),
    .div_cur  (div_cur),
    .out_clk  (out_clk),
    .out_tick (out_tick)
  );

  // ---------------- clock / reset block ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Tracks the position inside the current output period and whether the
  // first rising edge after reset has happened; out_clk follows from those.
  int           m_pos;
  bit           m_started;
  logic [W-1:0] m_div;
  logic [W-1:0] m_pend_val;
  bit           m_pend;
  bit           m_ack;
  bit           m_err;
  bit           m_tick;

  task automatic model_step(input logic r, input logic e, input logic l, input logic [W-1:0] v);
    if (r) begin
      m_pos = 0; m_started = 0; m_div = 16'd6; m_pend = 0;
      m_ack = 0; m_err = 0; m_tick = 0;
    end else begin
      m_ack  = 0;
      m_tick = 0;
      if (e) begin
        if (m_pos == int'(m_div) - 1) begin
          m_pos = 0; m_started = 1; m_tick = 1;
          if (m_pend) begin
            m_div = m_pend_val; m_pend = 0; m_ack = 1;
          end
        end else begin
          m_pos = m_pos + 1;
        end
      end
      m_err = l && (v < 2);
      if (l && v >= 2) begin
        m_pend_val = v; m_pend = 1;
      end
    end
  endtask

  function automatic logic [PW-1:0] model_out();
    logic mc;
    mc = m_started && (m_pos < int'(m_div) - int'(m_div) / 2);
    return {m_ack, m_err, m_pend, m_div, mc, m_tick};
  endfunction

  function automatic logic [PW-1:0] dut_out();
    return {div_ack, div_err, pending, div_cur, out_clk, out_tick};
  endfunction

  // ---------------- scoreboard ----------------
  logic [PW-1:0] exp_q[$];

  // ---------------- driver ----------------
  task automatic cycle(input logic r, input logic e, input logic l, input logic [W-1:0] v);
    logic [PW-1:0] ex;
    rst = r; en = e; div_load = l; div_val = v;
    @(posedge clk);
    model_step(r, e, l, v);
    exp_q.push_back(model_out());
    #1;
    ex = exp_q.pop_front();
    check("scoreboard", 32'(dut_out()), 32'(ex));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0, 16'd0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic         rst, en, load;
    logic [W-1:0] val;
    logic         e_clk, e_tick, e_ack, e_err, e_pend;
    logic [W-1:0] e_cur;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(input logic r, e, l, input logic [W-1:0] v,
                              input logic c, t, a, er, p, input logic [W-1:0] cur);
    vec_t x;
    x.rst = r; x.en = e; x.load = l; x.val = v;
    x.e_clk = c; x.e_tick = t; x.e_ack = a; x.e_err = er; x.e_pend = p; x.e_cur = cur;
    return x;
  endfunction

  initial begin
    int   got;
    int   acks;
    int   highs;
    int   ticks;
    int   guard;
    logic hold_ok;

    rst = 1'b1; en = 1'b0; div_load = 1'b0; div_val = '0;
    m_pos = 0; m_started = 0; m_div = 16'd6; m_pend_val = 16'd6;
    m_pend = 0; m_ack = 0; m_err = 0; m_tick = 0;

    // Reset, then D=6: low until the 6th edge, 3 high / 3 low, illegal loads.
    tbl[0]  = mk(1, 0, 0, 0,  0, 0, 0, 0, 0, 6);
    tbl[1]  = mk(0, 1, 0, 0,  0, 0, 0, 0, 0, 6);
    tbl[2]  = mk(0, 1, 0, 0,  0, 0, 0, 0, 0, 6);
    tbl[3]  = mk(0, 1, 0, 0,  0, 0, 0, 0, 0, 6);
    tbl[4]  = mk(0, 1, 0, 0,  0, 0, 0, 0, 0, 6);
    tbl[5]  = mk(0, 1, 0, 0,  0, 0, 0, 0, 0, 6);
    tbl[6]  = mk(0, 1, 0, 0,  1, 1, 0, 0, 0, 6);
    tbl[7]  = mk(0, 1, 0, 0,  1, 0, 0, 0, 0, 6);
    tbl[8]  = mk(0, 1, 0, 0,  1, 0, 0, 0, 0, 6);
    tbl[9]  = mk(0, 1, 0, 0,  0, 0, 0, 0, 0, 6);
    tbl[10] = mk(0, 1, 0, 0,  0, 0, 0, 0, 0, 6);
    tbl[11] = mk(0, 1, 0, 0,  0, 0, 0, 0, 0, 6);
    tbl[12] = mk(0, 1, 0, 0,  1, 1, 0, 0, 0, 6);
    tbl[13] = mk(0, 1, 1, 1,  1, 0, 0, 1, 0, 6);
    tbl[14] = mk(0, 1, 1, 0,  1, 0, 0, 1, 0, 6);
    tbl[15] = mk(0, 1, 0, 0,  0, 0, 0, 0, 0, 6);

    for (int i = 0; i < 16; i++) begin
      cycle(tbl[i].rst, tbl[i].en, tbl[i].load, tbl[i].val);
      check($sformatf("table[%0d]", i), 32'(dut_out()),
            32'({tbl[i].e_ack, tbl[i].e_err, tbl[i].e_pend, tbl[i].e_cur,
                 tbl[i].e_clk, tbl[i].e_tick}));
    end

    // Load 5 mid-period: pending until the boundary, one ack, then 3/2.
    cycle(1'b0, 1'b1, 1'b1, 16'd5);
    check("t2_pending", 32'(pending), 32'd1);
    got = 0;
    for (int k = 0; k < 20 && got == 0; k++) begin
      cycle(1'b0, 1'b1, 1'b0, 16'd0);
      if (div_ack) got = 1;
    end
    check("t2_ack_seen", 32'(got), 32'd1);
    check("t2_div_cur", 32'(div_cur), 32'd5);
    highs = 0; acks = 0; ticks = 0;
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 1'b1, 1'b0, 16'd0);
      highs += int'(out_clk); acks += int'(div_ack); ticks += int'(out_tick);
    end
    check("t2_high_cycles", 32'(highs), 32'd6);
    check("t2_ticks", 32'(ticks), 32'd2);
    check("t2_no_extra_ack", 32'(acks), 32'd0);

    // Illegal loads: error pulses, state untouched.
    cycle(1'b0, 1'b1, 1'b1, 16'd1);
    check("t3_err_1", 32'(div_err), 32'd1);
    cycle(1'b0, 1'b1, 1'b1, 16'd0);
    check("t3_err_0", 32'(div_err), 32'd1);
    cycle(1'b0, 1'b1, 1'b0, 16'd0);
    check("t3_err_clear", 32'(div_err), 32'd0);
    check("t3_state", 32'({pending, div_cur}), 32'({1'b0, 16'd5}));

    // Two loads before one boundary: last wins, single ack, 5/5 waveform.
    guard = 0;
    while (m_pos != 0 && guard < 20) begin cycle(1'b0, 1'b1, 1'b0, 16'd0); guard++; end
    check("t4_sync", 32'(guard < 20), 32'd1);
    cycle(1'b0, 1'b1, 1'b1, 16'd4);
    cycle(1'b0, 1'b1, 1'b1, 16'd10);
    acks = 0;
    for (int k = 0; k < 12; k++) begin
      cycle(1'b0, 1'b1, 1'b0, 16'd0);
      acks += int'(div_ack);
    end
    check("t4_single_ack", 32'(acks), 32'd1);
    check("t4_div_cur", 32'(div_cur), 32'd10);
    highs = 0;
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 1'b1, 1'b0, 16'd0);
      highs += int'(out_clk);
    end
    check("t4_high_of_10", 32'(highs), 32'd5);

    // Load 7 exactly on a boundary edge: not applied until one period later.
    guard = 0;
    while (m_pos != int'(m_div) - 1 && guard < 20) begin cycle(1'b0, 1'b1, 1'b0, 16'd0); guard++; end
    check("t4_find_boundary", 32'(guard < 20), 32'd1);
    cycle(1'b0, 1'b1, 1'b1, 16'd7);
    check("t4_bnd_tick", 32'(out_tick), 32'd1);
    check("t4_bnd_state", 32'({div_ack, pending, div_cur}), 32'({1'b0, 1'b1, 16'd10}));
    got = 0; guard = 0;
    for (int k = 0; k < 15 && got == 0; k++) begin
      cycle(1'b0, 1'b1, 1'b0, 16'd0);
      guard++;
      if (div_ack) got = 1;
    end
    check("t4_late_ack", 32'(got), 32'd1);
    check("t4_late_ack_delay", 32'(guard), 32'd10);
    check("t4_div7", 32'(div_cur), 32'd7);

    // en=0 for 4 cycles in the high phase (D=7, H=4, paused after one high edge).
    guard = 0;
    while (!(m_pos == 1 && m_started) && guard < 20) begin cycle(1'b0, 1'b1, 1'b0, 16'd0); guard++; end
    check("t5_sync", 32'(guard < 20), 32'd1);
    hold_ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 1'b0, 1'b0, 16'd0);
      if (out_clk !== 1'b1 || out_tick !== 1'b0) hold_ok = 1'b0;
    end
    check("t5_frozen", 32'(hold_ok), 32'd1);
    cycle(1'b0, 1'b1, 1'b0, 16'd0);
    check("t5_resume_hi_a", 32'(out_clk), 32'd1);
    cycle(1'b0, 1'b1, 1'b0, 16'd0);
    check("t5_resume_hi_b", 32'(out_clk), 32'd1);
    cycle(1'b0, 1'b1, 1'b0, 16'd0);
    check("t5_resume_lo", 32'(out_clk), 32'd0);

    // Reset mid-period with a pending load: discarded, no ack later.
    cycle(1'b0, 1'b1, 1'b1, 16'd9);
    check("t6_pending", 32'(pending), 32'd1);
    cycle(1'b1, 1'b1, 1'b0, 16'd0);
    check("t6_reset_vals", 32'(dut_out()), 32'({1'b0, 1'b0, 1'b0, 16'd6, 1'b0, 1'b0}));
    acks = 0;
    for (int k = 0; k < 14; k++) begin
      cycle(1'b0, 1'b1, 1'b0, 16'd0);
      acks += int'(div_ack);
    end
    check("t6_no_ack", 32'(acks), 32'd0);
    check("t6_div_cur", 32'(div_cur), 32'd6);

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      cycle(logic'($urandom_range(0, 199) == 0),
            logic'($urandom_range(0, 9) != 0),
            logic'($urandom_range(0, 5) == 0),
            W'($urandom_range(0, 12)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
